// File: rtl/if_fetch_unit.sv
// IF-stage fetch engine: owns the PC, issues one instruction fetch at a time and
// feeds the IF/ID register, with a one-entry skid for responses that arrive under stall.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_stall,
  input  logic        br_taken,
  input  logic [31:0] NPC_beq,
  input  logic        jump,
  input  logic [31:0] NPC_j,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IFID_PC,
  output logic [31:0] IFID_Instr,
  output logic        IFID_valid
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_req_pc;
  logic        r_drop;
  logic [31:0] r_skid;

  logic        w_redirect;
  logic [31:0] w_target;
  logic [31:0] w_pc_inc;
  logic        w_ifid_free;
  logic        w_load;
  logic [31:0] w_load_data;

  // Redirect selection, IF/ID load decision and load source.
  always_comb begin
    w_redirect  = br_taken | jump;
    w_target    = 32'h0000_0000;
    w_pc_inc    = r_req_pc + 32'd4;
    w_ifid_free = ~IFID_valid | ~id_stall;
    w_load      = 1'b0;
    w_load_data = imem_rdata;
    if (jump) begin
      w_target = {NPC_j[31:2], 2'b00};
    end else begin
      w_target = {NPC_beq[31:2], 2'b00};
    end
    case (r_state)
      S_WAIT: begin
        w_load      = ~w_redirect & imem_rvalid & ~r_drop & w_ifid_free;
        w_load_data = imem_rdata;
      end
      S_HOLD: begin
        w_load      = ~w_redirect & ~id_stall;
        w_load_data = r_skid;
      end
      default: begin
        w_load      = 1'b0;
        w_load_data = imem_rdata;
      end
    endcase
  end

  // Request is suppressed while reset is asserted.
  always_comb begin
    imem_req  = (r_state == S_FETCH) & ~rst;
    imem_addr = r_pc;
  end

  // Fetch FSM, PC and IF/ID pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_req_pc   <= 32'h0000_0000;
      r_drop     <= 1'b0;
      r_skid     <= 32'h0000_0000;
      IFID_PC    <= 32'h0000_0000;
      IFID_Instr <= 32'h0000_0000;
      IFID_valid <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_ready) begin
            r_req_pc <= r_pc;
            r_drop   <= w_redirect;
            r_state  <= S_WAIT;
          end else begin
            r_state  <= S_FETCH;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            // A stale or redirected response is dropped on the floor.
            if (r_drop || w_redirect) begin
              r_drop  <= 1'b0;
              r_state <= S_FETCH;
            end else if (w_ifid_free) begin
              r_state <= S_FETCH;
            end else begin
              r_skid  <= imem_rdata;
              r_state <= S_HOLD;
            end
          end else if (w_redirect) begin
            r_drop <= 1'b1;
          end else begin
            r_drop <= r_drop;
          end
        end
        S_HOLD: begin
          if (w_redirect || !id_stall) begin
            r_state <= S_FETCH;
          end else begin
            r_state <= S_HOLD;
          end
        end
        default: begin
          r_state <= S_FETCH;
        end
      endcase

      if (w_redirect) begin
        r_pc       <= w_target;
        IFID_valid <= 1'b0;
      end else if (w_load) begin
        r_pc       <= w_pc_inc;
        IFID_PC    <= r_req_pc;
        IFID_Instr <= w_load_data;
        IFID_valid <= 1'b1;
      end else if (IFID_valid && !id_stall) begin
        IFID_valid <= 1'b0;
      end else begin
        IFID_valid <= IFID_valid;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus randomized traffic, checked
// against a transaction-level model of the fetch pipeline and a simple memory.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic        id_stall;
  logic        br_taken;
  logic [31:0] NPC_beq;
  logic        jump;
  logic [31:0] NPC_j;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] IFID_PC;
  logic [31:0] IFID_Instr;
  logic        IFID_valid;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .id_stall   (id_stall),
    .br_taken   (br_taken),
    .NPC_beq    (NPC_beq),
    .jump       (jump),
    .NPC_j      (NPC_j),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .IFID_PC    (IFID_PC),
    .IFID_Instr (IFID_Instr),
    .IFID_valid (IFID_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // memory environment
  bit          pending;
  logic [31:0] pend_addr;
  int          cnt;
  int          rdy_pct;
  int          dly_lo;
  int          dly_hi;

  // reference model: PC, one outstanding fetch, one buffered word, IF/ID contents
  logic [31:0] m_pc;
  bit          m_busy;
  bit          m_stale;
  logic [31:0] m_req_pc;
  bit          m_buf;
  logic [31:0] m_buf_data;
  bit          m_v;
  logic [31:0] m_ifpc;
  logic [31:0] m_ifins;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h3C1F_9A5B;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0000_0000; m_busy = 0; m_stale = 0; m_req_pc = 32'h0;
    m_buf = 0; m_buf_data = 32'h0; m_v = 0; m_ifpc = 32'h0; m_ifins = 32'h0;
  endtask

  task automatic cyc(input logic st, input logic br, input logic [31:0] bt,
                     input logic jp, input logic [31:0] jt, input logic rs);
    logic rdy, rv, exp_req, red, free, dlv;
    logic [31:0] tgt, dpc, dins;
    rv  = pending && (cnt == 0);
    rdy = !pending && ($urandom_range(99) < rdy_pct);
    rst = rs; id_stall = st; br_taken = br; NPC_beq = bt; jump = jp; NPC_j = jt;
    imem_ready = rdy; imem_rvalid = rv;
    imem_rdata = rv ? mem_word(pend_addr) : $urandom();
    #1;
    exp_req = !rs && !m_busy && !m_buf;
    chk("req", imem_req, exp_req);
    if (exp_req) chk("addr", imem_addr, m_pc);
    chk("valid", IFID_valid, m_v);
    if (m_v) begin
      chk("ifid_pc", IFID_PC, m_ifpc);
      chk("ifid_instr", IFID_Instr, m_ifins);
    end
    // memory side: retire delivered response, accept new request
    if (rv) pending = 0;
    else if (pending) cnt--;
    if (exp_req && rdy) begin
      pending = 1; pend_addr = m_pc; cnt = $urandom_range(dly_hi, dly_lo) - 1;
    end
    // model update
    if (rs) begin
      model_reset();
    end else begin
      red = br | jp;
      tgt = jp ? jt : bt;
      tgt[1:0] = 2'b00;
      free = !m_v || !st;
      dlv = 0; dpc = 32'h0; dins = 32'h0;
      if (!m_busy && !m_buf) begin
        if (rdy) begin m_busy = 1; m_req_pc = m_pc; m_stale = red; end
      end else if (m_busy) begin
        if (rv) begin
          m_busy = 0;
          if (!m_stale && !red) begin
            if (free) begin dlv = 1; dpc = m_req_pc; dins = mem_word(m_req_pc); end
            else begin m_buf = 1; m_buf_data = mem_word(m_req_pc); end
          end
          m_stale = 0;
        end else if (red) begin
          m_stale = 1;
        end
      end else begin
        if (red) m_buf = 0;
        else if (!st) begin dlv = 1; dpc = m_req_pc; dins = m_buf_data; m_buf = 0; end
      end
      if (red) begin
        m_pc = tgt; m_v = 0;
      end else if (dlv) begin
        m_pc = dpc + 32'd4; m_v = 1; m_ifpc = dpc; m_ifins = dins;
      end else if (m_v && !st) begin
        m_v = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic st);
    cyc(st, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic rst_cyc();
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; id_stall = 1'b0; br_taken = 1'b0; NPC_beq = 32'h0; jump = 1'b0;
    NPC_j = 32'h0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    pending = 0; pend_addr = 32'h0; cnt = 0;
    rdy_pct = 100; dly_lo = 1; dly_hi = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // 1: sequential fetch
    rst_cyc();
    chk("rst_pc", IFID_PC, 32'h0);
    chk("rst_instr", IFID_Instr, 32'h0);
    chk("rst_valid", IFID_valid, 32'h0);
    chk("rst_req", imem_req, 32'h0);
    repeat (6) idle(1'b0);
    chk("t1_pc", IFID_PC, 32'h8);
    chk("t1_instr", IFID_Instr, mem_word(32'h8));
    chk("t1_addr", imem_addr, 32'hC);

    // 2: stall while response arrives -> hold in skid
    rst_cyc();
    repeat (4) idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    chk("t2_hold_req", imem_req, 32'h0);
    chk("t2_hold_pc", IFID_PC, 32'h4);
    chk("t2_hold_valid", IFID_valid, 32'h1);
    idle(1'b0);
    chk("t2_pc", IFID_PC, 32'h8);
    chk("t2_addr", imem_addr, 32'hC);
    chk("t2_req", imem_req, 32'h1);

    // 3: jump while waiting for addr 8
    dly_lo = 2; dly_hi = 2;
    rst_cyc();
    repeat (7) idle(1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0040, 1'b0);
    chk("t3_flush", IFID_valid, 32'h0);
    idle(1'b0);
    chk("t3_req", imem_req, 32'h1);
    chk("t3_addr", imem_addr, 32'h40);
    chk("t3_drop", IFID_valid, 32'h0);
    repeat (3) idle(1'b0);
    chk("t3_pc", IFID_PC, 32'h40);
    chk("t3_valid", IFID_valid, 32'h1);

    // 4: branch and jump together while in HOLD
    dly_lo = 1; dly_hi = 1;
    rst_cyc();
    repeat (4) idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    cyc(1'b1, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0200, 1'b0);
    chk("t4_addr", imem_addr, 32'h200);
    chk("t4_valid", IFID_valid, 32'h0);
    repeat (2) idle(1'b0);
    chk("t4_pc", IFID_PC, 32'h200);

    // 5: reset during WAIT, stale response afterwards
    dly_lo = 2; dly_hi = 2;
    rst_cyc();
    idle(1'b0);
    rst_cyc();
    chk("t5_rst_req", imem_req, 32'h0);
    dly_lo = 1; dly_hi = 1;
    idle(1'b0);
    chk("t5_stale", IFID_valid, 32'h0);
    chk("t5_addr", imem_addr, 32'h0);
    idle(1'b0);
    chk("t5_wait", IFID_valid, 32'h0);
    idle(1'b0);
    chk("t5_fresh", IFID_valid, 32'h1);
    chk("t5_pc", IFID_PC, 32'h0);

    // 6: PC wrap
    rst_cyc();
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    repeat (3) idle(1'b0);
    chk("t6_pc", IFID_PC, 32'hFFFF_FFFC);
    chk("t6_addr", imem_addr, 32'h0);
    chk("t6_req", imem_req, 32'h1);

    // randomized traffic
    rdy_pct = 70; dly_lo = 1; dly_hi = 3;
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(99) < 30, $urandom_range(99) < 6, $urandom(),
          $urandom_range(99) < 5, $urandom(), $urandom_range(199) < 1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
